// File: rtl/mag_approx_pipe.sv
// Pipelined alpha-max-beta-min magnitude estimator with valid/ready stream and peak hold.
// Optional macro MAG_ROUND_EN: beta terms round half-up instead of truncating.
module mag_approx_pipe #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   mag,
    output logic [W:0]   peak,
    input  logic         peak_clr
);
    localparam int OW = W + 1;
    localparam int TW = OW + 2;

    logic          adv;
    logic          v1;
    logic          v2;
    logic          v3;
    logic [W-1:0]  s1_ax;
    logic [W-1:0]  s1_ay;
    logic [1:0]    s1_mode;
    logic [W-1:0]  s2_mx;
    logic [W-1:0]  s2_mn;
    logic [1:0]    s2_mode;
    logic [W-1:0]  s3_mx;
    logic [TW-1:0] s3_term;
    logic [TW-1:0] mn_x;
    logic [TW-1:0] mn_x3;
    logic [TW-1:0] term;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Most negative input maps to 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        if (SIGNED && v[W-1]) begin
            abs_w = ~v + W'(1);
        end else begin
            abs_w = v;
        end
    endfunction

    always_comb begin
        mn_x  = TW'(s2_mn);
        mn_x3 = (mn_x << 1) + mn_x;
        term  = '0;
`ifdef MAG_ROUND_EN
        case (s2_mode)
            2'd0:    term = (mn_x + TW'(1)) >> 1;
            2'd1:    term = (mn_x + TW'(2)) >> 2;
            2'd2:    term = (mn_x3 + TW'(4)) >> 3;
            default: term = '0;
        endcase
`else
        case (s2_mode)
            2'd0:    term = mn_x >> 1;
            2'd1:    term = mn_x >> 2;
            2'd2:    term = mn_x3 >> 3;
            default: term = '0;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            s1_ax     <= '0;
            s1_ay     <= '0;
            s1_mode   <= '0;
            s2_mx     <= '0;
            s2_mn     <= '0;
            s2_mode   <= '0;
            s3_mx     <= '0;
            s3_term   <= '0;
            mag       <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (in_valid) begin
                s1_ax   <= abs_w(x);
                s1_ay   <= abs_w(y);
                s1_mode <= mode;
            end
            if (v1) begin
                s2_mx   <= (s1_ax >= s1_ay) ? s1_ax : s1_ay;
                s2_mn   <= (s1_ax >= s1_ay) ? s1_ay : s1_ax;
                s2_mode <= s1_mode;
            end
            if (v2) begin
                s3_mx   <= s2_mx;
                s3_term <= term;
            end
            // mag only loads real results so it holds across bubbles.
            if (v3) begin
                mag <= OW'(TW'(s3_mx) + s3_term);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (out_valid && out_ready) begin
            if (peak_clr || (mag > peak)) begin
                peak <= mag;
            end
        end else if (peak_clr) begin
            peak <= '0;
        end
    end

endmodule

// File: tb/tb_mag_approx_pipe.sv
// Directed bench for mag_approx_pipe: unsigned and signed W=8 instances driven in lockstep.
module tb_mag_approx_pipe;

`ifdef MAG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] mode;
        logic [8:0] exp_u;
        logic [8:0] exp_s;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] mode;
    logic       out_ready;
    logic       peak_clr;
    logic       u_in_ready, s_in_ready;
    logic       u_out_valid, s_out_valid;
    logic [8:0] u_mag, s_mag, u_peak, s_peak;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_deliv = 0;
    vec_t tbl [12];
    vec_t exp_q [$];
    vec_t cur;
    vec_t sb_e;

    mag_approx_pipe #(.W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(u_out_valid), .out_ready(out_ready),
        .mag(u_mag), .peak(u_peak), .peak_clr(peak_clr)
    );

    mag_approx_pipe #(.W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
        .mag(s_mag), .peak(s_peak), .peak_clr(peak_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int xv, input int yv, input int m, input int eu, input int es);
        vec_t v;
        v.x     = 8'(xv);
        v.y     = 8'(yv);
        v.mode  = 2'(m);
        v.exp_u = 9'(eu);
        v.exp_s = 9'(es);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        cur      = v;
        x        = v.x;
        y        = v.y;
        mode     = v.mode;
        in_valid = 1'b1;
    endtask

    task automatic clr_in();
        in_valid = 1'b0;
        x        = 8'hxx;
        y        = 8'hxx;
        mode     = 2'bxx;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard: expectations queued at acceptance, compared in order at delivery.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (u_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got mag %0d, expected no delivery", u_mag);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_mag_unsigned", u_mag, sb_e.exp_u);
                    chk("sb_mag_signed", s_mag, sb_e.exp_s);
                    n_deliv++;
                end
            end
            if (in_valid && u_in_ready) exp_q.push_back(cur);
        end
    end

    initial begin
        int k;
        int d0;
        tbl[0]  = mk(3,    4,    0, RND ? 6 : 5,     RND ? 6 : 5);
        tbl[1]  = mk(200,  100,  0, 250,             128);
        tbl[2]  = mk(200,  100,  1, 225,             114);
        tbl[3]  = mk(200,  100,  2, RND ? 238 : 237, 121);
        tbl[4]  = mk(200,  100,  3, 200,             100);
        tbl[5]  = mk(8'h80, 8'hFF, 0, 319,           RND ? 129 : 128);
        tbl[6]  = mk(255,  255,  0, RND ? 383 : 382, RND ? 2 : 1);
        tbl[7]  = mk(0,    0,    2, 0,               0);
        tbl[8]  = mk(7,    10,   1, RND ? 12 : 11,   RND ? 12 : 11);
        tbl[9]  = mk(8'h7F, 8'h81, 2, RND ? 177 : 176, RND ? 175 : 174);
        tbl[10] = mk(100,  0,    3, 100,             100);
        tbl[11] = mk(40,   0,    0, 40,              40);

        rst_n     = 1'b0;
        out_ready = 1'b0;
        peak_clr  = 1'b0;
        clr_in();
        tick();
        tick();
        chk("rst_out_valid", u_out_valid, 0);
        chk("rst_mag", u_mag, 0);
        chk("rst_peak", u_peak, 0);
        chk("rst_in_ready", u_in_ready, 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        // Latency: accepted at edge N, visible after edge N+3, one-cycle pulse.
        set_in(tbl[0]);
        tick();
        clr_in();
        tick();
        chk("lat_n1_valid", u_out_valid, 0);
        tick();
        chk("lat_n2_valid", u_out_valid, 0);
        tick();
        chk("lat_n3_valid", u_out_valid, 1);
        chk("lat_n3_mag", u_mag, tbl[0].exp_u);
        tick();
        chk("pulse_valid_low", u_out_valid, 0);
        chk("mag_hold", u_mag, tbl[0].exp_u);

        // Back-to-back stream of the whole table; last result must appear 3 edges after last accept.
        d0 = n_deliv;
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i]);
            tick();
        end
        clr_in();
        tick();
        tick();
        tick();
        chk("stream_last_valid", u_out_valid, 1);
        @(negedge clk);
        #1;
        chk("stream_no_gaps", exp_q.size(), 0);
        chk("stream_count", n_deliv - d0, 12);
        tick();

        // Backpressure: stall with a full pipe, then release.
        d0 = n_deliv;
        for (int i = 0; i < 4; i++) begin
            set_in(tbl[i]);
            tick();
        end
        chk("bp_first_valid", u_out_valid, 1);
        out_ready = 1'b0;
        set_in(tbl[4]);
        #1;
        chk("bp_in_ready_low", u_in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall_in_ready", u_in_ready, 0);
            chk("bp_stall_valid", u_out_valid, 1);
            chk("bp_stall_mag", u_mag, tbl[0].exp_u);
        end
        out_ready = 1'b1;
        tick();
        clr_in();
        drain("bp_drain", 20);
        chk("bp_count", n_deliv - d0, 5);
        tick();

        // Peak hold, then clear coinciding with a delivery.
        do_reset();
        set_in(tbl[0]);
        tick();
        set_in(tbl[1]);
        tick();
        set_in(tbl[10]);
        tick();
        clr_in();
        drain("peak_drain", 20);
        tick();
        chk("peak_max_u", u_peak, 250);
        chk("peak_max_s", s_peak, 128);
        set_in(tbl[11]);
        tick();
        clr_in();
        k = 0;
        while (!u_out_valid && k < 10) begin
            tick();
            k++;
        end
        chk("peak40_arrive", u_out_valid, 1);
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        chk("peak_clr_deliver_u", u_peak, 40);
        chk("peak_clr_deliver_s", s_peak, 40);

        // Reset with two samples in flight: everything cleared, nothing stale emerges.
        set_in(tbl[1]);
        tick();
        set_in(tbl[2]);
        tick();
        clr_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", u_out_valid, 0);
        chk("midrst_mag", u_mag, 0);
        chk("midrst_peak", u_peak, 0);
        chk("midrst_in_ready", u_in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_stale", u_out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mag_approx_pipe.md
Name: mag_approx_pipe

Overview:
- Parametrised, pipelined alpha-max-beta-min magnitude estimator: |v| ≈ max(|x|,|y|) + beta·min(|x|,|y|).
- Adds signed-input support, a per-sample beta mode select, a valid/ready stream handshake and a peak-hold register.
- Sits between the ui_in/uio_in sample capture and any downstream consumer (display, threshold logic) in the top-level project.

Parameters:
- W, 8, input component width in bits; legal range 4..16.
- SIGNED, 0, 1 = x/y are two's complement and take absolute value first; 0 = unsigned.
- OW, W+1 (localparam, not overridable), output magnitude width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  x/y/mode present a sample.
- in_ready  output  1  block accepts the sample this cycle.
- x  input  W  component X.
- y  input  W  component Y.
- mode  input  2  beta select, captured with the sample.
- out_valid  output  1  mag holds a result.
- out_ready  input  1  consumer accepts mag this cycle.
- mag  output  OW  magnitude estimate.
- peak  output  OW  largest mag delivered since reset/clear.
- peak_clr  input  1  clear the peak register.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits, out_valid, mag, peak and internal data registers go to 0. Reset mid-stream drops in-flight samples silently.
- Global advance: adv = out_ready | ~out_valid; in_ready = adv (combinational).
- Transfers:
  - A sample is accepted when in_valid & in_ready.
  - A result is delivered when out_valid & out_ready.
- Stalling: when adv=0, every pipeline register (data and valid) holds. Bubbles are not collapsed.
- Stage 1, accept: ax = |x|, ay = |y| (W bits unsigned).
  - SIGNED=1: |-2^(W-1)| = 2^(W-1), representable unsigned; no saturation.
  - mode is registered alongside the sample.
- Stage 2: mx = max(ax,ay); mn = min(ax,ay). Ties give mx = mn = ax.
- Stage 3: term by mode, computed in OW+2 bits:
  - 0: mn>>1
  - 1: mn>>2
  - 2: (3·mn)>>3
  - 3: 0 (max only)
- Result: mag = mx + term. Provably < 2^OW; no overflow or saturation logic.
- Latency: a sample accepted at edge N appears on mag/out_valid after edge N+3 when adv stays 1. Throughput is 1 sample per cycle.
- mag and out_valid are registered and only change on advancing edges. mag holds its last value while out_valid=0.
- Peak register:
  - On each delivery edge, peak <= max(peak, mag).
  - peak_clr=1 forces peak <= 0 on that edge.
  - Simultaneous clear and delivery: peak <= mag of the delivered result (clear then compare).
- in_valid=0 while adv=1 inserts a bubble (stage valid bit 0).
- x/y/mode are don't-care when in_valid=0.

Optional Feature:
- Macro: MAG_ROUND_EN.
- Defined: beta terms round half-up.
  - mode 0: (mn+1)>>1
  - mode 1: (mn+2)>>2
  - mode 2: (3·mn+4)>>3
  - Max result still < 2^OW.
- Undefined: truncating terms as in Behaviour. Ports, latency and handshake are identical either way.

Test Plan:
- W=8, SIGNED=0, out_ready=1, mode=0, x=3, y=4 → 3 cycles later mag=5 (4+1), out_valid pulses for one cycle. Same with MAG_ROUND_EN → mag=6.
- mode sweep on x=200, y=100, consecutive cycles:
  - mode 0 → 250
  - mode 1 → 225
  - mode 2 → 237
  - mode 3 → 200
  - Results arrive in order on back-to-back cycles.
- SIGNED=1, W=8: x=8'h80 (-128), y=8'hFF (-1), mode 0 → mag=128. x=255, y=255, SIGNED=0, mode 0 → mag=382 (no overflow, OW=9).
- Backpressure:
  - Stream 5 samples with out_ready=0 after the first result appears → in_ready=0 and mag stable.
  - Release out_ready → all 5 results delivered in order, none lost or duplicated.
- Peak: deliver mags 5, 250, 100 → peak=250. Then peak_clr on the same edge as delivering 40 → peak=40.
- Reset: assert rst_n=0 for 1 cycle with 2 samples in flight → next cycle out_valid=0, mag=0, peak=0, in_ready=1, and no stale results emerge afterwards.
